// File: rtl/intr_ctrl.sv
// Interrupt initiator: edge-detects four IRQ lines, arbitrates by fixed priority,
// handshakes with the pipeline and issues the EPC-write / vector-jump pulse.
module intr_ctrl #(
  parameter int                     IM_ADDR_BIT = 10,
  parameter logic [IM_ADDR_BIT-1:0] VEC_BASE    = 10'h100,
  parameter logic [IM_ADDR_BIT-1:0] VEC_STRIDE  = 10'h020
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             irq_in,
  input  logic                   intr_en,
  input  logic [3:0]             intr_mask,
  input  logic [IM_ADDR_BIT-1:0] resume_pc,
  input  logic                   pipe_ack,
  input  logic                   is_eret,
  output logic                   intr_req,
  output logic                   epc_w_en,
  output logic [IM_ADDR_BIT-1:0] epc_w_data,
  output logic                   jmp_en,
  output logic [IM_ADDR_BIT-1:0] jmp_addr,
  output logic [3:0]             pending,
  output logic [3:0]             in_service
);

  typedef enum logic [1:0] {IDLE, REQ, ENTER, SERVICE} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             irq_prev_q;
  logic [3:0]             pending_q, pending_d;
  logic [3:0]             in_service_q, in_service_d;
  logic [IM_ADDR_BIT-1:0] pc_q, pc_d;
  logic [IM_ADDR_BIT-1:0] jmp_q, jmp_d;

  logic [3:0] edge_det, elig, sel_oh;
  logic [1:0] sel_id;
  logic       ack, eret;

  assign edge_det = irq_in & ~irq_prev_q;
  assign elig     = intr_en ? (pending_q & intr_mask) : 4'b0000;

  // Fixed priority, bit 3 wins.
  always_comb begin
    sel_id = 2'd0;
    if (elig[3])      sel_id = 2'd3;
    else if (elig[2]) sel_id = 2'd2;
    else if (elig[1]) sel_id = 2'd1;
    sel_oh = 4'b0001 << sel_id;
  end

  always_comb begin
    state_d = state_q;
    ack     = 1'b0;
    eret    = 1'b0;
    case (state_q)
      IDLE:    if (|elig) state_d = REQ;
      REQ: begin
        if (!(|elig)) state_d = IDLE;
        else if (pipe_ack) begin
          ack     = 1'b1;
          state_d = ENTER;
        end
      end
      ENTER:   state_d = SERVICE;
      SERVICE: if (is_eret) begin
        eret    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A fresh edge on the source being taken keeps it pending.
  always_comb begin
    pending_d    = (pending_q & ~(ack ? sel_oh : 4'b0000)) | edge_det;
    in_service_d = in_service_q;
    pc_d         = pc_q;
    jmp_d        = jmp_q;
    if (ack) begin
      in_service_d = sel_oh;
      pc_d         = resume_pc;
      jmp_d        = VEC_BASE + IM_ADDR_BIT'(sel_id) * VEC_STRIDE;
    end else if (eret) begin
      in_service_d = 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      irq_prev_q   <= 4'b0000;
      pending_q    <= 4'b0000;
      in_service_q <= 4'b0000;
      pc_q         <= '0;
      jmp_q        <= '0;
    end else begin
      state_q      <= state_d;
      irq_prev_q   <= irq_in;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      pc_q         <= pc_d;
      jmp_q        <= jmp_d;
    end
  end

  assign intr_req   = (state_q == REQ);
  assign epc_w_en   = (state_q == ENTER);
  assign jmp_en     = (state_q == ENTER);
  assign epc_w_data = pc_q;
  assign jmp_addr   = jmp_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: vector table plus hand-written corner sequences,
// with ENTER-pulse expectations queued at ack time and popped when the pulse appears.
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] irq_in;
  logic       intr_en;
  logic [3:0] intr_mask;
  logic [9:0] resume_pc;
  logic       pipe_ack;
  logic       is_eret;
  logic       intr_req, epc_w_en, jmp_en;
  logic [9:0] epc_w_data, jmp_addr;
  logic [3:0] pending, in_service;

  intr_ctrl dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .intr_en(intr_en),
    .intr_mask(intr_mask), .resume_pc(resume_pc), .pipe_ack(pipe_ack),
    .is_eret(is_eret), .intr_req(intr_req), .epc_w_en(epc_w_en),
    .epc_w_data(epc_w_data), .jmp_en(jmp_en), .jmp_addr(jmp_addr),
    .pending(pending), .in_service(in_service)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] pc;
    logic [9:0] jmp;
    logic [3:0] svc;
  } exp_t;

  typedef struct {
    logic [3:0] rise;
    logic [3:0] mask;
    logic [9:0] pc;
    int         id;
    logic [3:0] pend;
  } vec_t;

  exp_t sb[$];
  vec_t vt[4];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] vec_of(input int id);
    return 10'(32'h100 + id * 32'h020);
  endfunction

  // Waits for the request, acks, and checks the ENTER cycle; leaves the DUT in ENTER.
  task automatic ack_enter(input logic [9:0] pc, input int id);
    int   n;
    exp_t e;
    n = 0;
    while (!intr_req && n < 20) begin tick(); n++; end
    chk("intr_req_before_ack", 32'(intr_req), 32'd1);
    pipe_ack  = 1'b1;
    resume_pc = pc;
    sb.push_back('{pc: pc, jmp: vec_of(id), svc: 4'(1 << id)});
    tick();
    pipe_ack = 1'b0;
    n = 0;
    while (!jmp_en && n < 5) begin tick(); n++; end
    chk("jmp_en_pulse", 32'(jmp_en), 32'd1);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: entry pulse with empty queue");
    end else begin
      e = sb.pop_front();
      chk("epc_w_en", 32'(epc_w_en), 32'd1);
      chk("epc_w_data", 32'(epc_w_data), 32'(e.pc));
      chk("jmp_addr", 32'(jmp_addr), 32'(e.jmp));
      chk("in_service_enter", 32'(in_service), 32'(e.svc));
    end
  endtask

  task automatic do_eret();
    is_eret = 1'b1;
    tick();
    is_eret = 1'b0;
    chk("in_service_after_eret", 32'(in_service), 32'd0);
    chk("intr_req_after_eret", 32'(intr_req), 32'd0);
  endtask

  task automatic serve(input logic [9:0] pc, input int id);
    ack_enter(pc, id);
    tick();
    chk("enter_one_cycle", 32'(jmp_en), 32'd0);
    do_eret();
  endtask

  initial begin
    int n;
    logic quiet;
    vt[0] = '{rise: 4'b0010, mask: 4'hF,    pc: 10'h045, id: 1, pend: 4'b0000};
    vt[1] = '{rise: 4'b1001, mask: 4'hF,    pc: 10'h2A0, id: 3, pend: 4'b0001};
    vt[2] = '{rise: 4'b0101, mask: 4'b1011, pc: 10'h3FF, id: 0, pend: 4'b0100};
    vt[3] = '{rise: 4'b1111, mask: 4'hF,    pc: 10'h001, id: 3, pend: 4'b0111};

    rst_n = 1'b0; irq_in = 4'h0; intr_en = 1'b1; intr_mask = 4'hF;
    resume_pc = 10'h0; pipe_ack = 1'b0; is_eret = 1'b0;
    tick(); tick();
    chk("rst_outputs", {intr_req, epc_w_en, jmp_en, epc_w_data, jmp_addr, pending, in_service}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Latency: pending one cycle after the rise, request one cycle later, held until ack.
    irq_in[1] = 1'b1;
    tick();
    chk("pending_latency", 32'(pending), 32'b0010);
    chk("req_not_yet", 32'(intr_req), 32'd0);
    tick();
    chk("req_latency", 32'(intr_req), 32'd1);
    tick();
    chk("req_held", 32'(intr_req), 32'd1);
    serve(10'h045, 1);

    foreach (vt[k]) begin
      irq_in = 4'h0; intr_mask = vt[k].mask;
      tick();
      irq_in = vt[k].rise;
      tick();
      ack_enter(vt[k].pc, vt[k].id);
      chk("pending_after_ack", 32'(pending), 32'(vt[k].pend));
      tick();
      do_eret();
      intr_mask = 4'hF;
      for (int i = 3; i >= 0; i--)
        if (vt[k].pend[i]) serve(vt[k].pc + 10'(i), i);
      chk("pending_drained", 32'(pending), 32'd0);
    end

    // Masked source stays pending and is requested once unmasked.
    irq_in = 4'h0; intr_mask = 4'b1101;
    tick();
    irq_in[1] = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin tick(); if (intr_req) quiet = 1'b0; end
    chk("masked_no_req", 32'(quiet), 32'd1);
    chk("masked_pending", 32'(pending), 32'b0010);
    intr_mask = 4'hF;
    tick();
    chk("unmask_req", 32'(intr_req), 32'd1);
    serve(10'h100, 1);

    // Global enable drops while requesting: withdraw cleanly.
    irq_in = 4'h0;
    tick();
    irq_in[2] = 1'b1;
    tick(); tick();
    chk("req_en_drop_pre", 32'(intr_req), 32'd1);
    intr_en = 1'b0;
    tick();
    chk("req_en_drop", 32'(intr_req), 32'd0);
    chk("no_epc_en_drop", 32'(epc_w_en), 32'd0);
    chk("pending_kept", 32'(pending), 32'b0100);
    intr_en = 1'b1;
    serve(10'h077, 2);

    // Same source re-rises while in service: held off until eret.
    irq_in = 4'h0;
    tick();
    irq_in[2] = 1'b1;
    tick();
    ack_enter(10'h050, 2);
    tick();
    irq_in[2] = 1'b0;
    tick();
    irq_in[2] = 1'b1;
    tick();
    chk("rerise_pending", 32'(pending), 32'b0100);
    quiet = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); if (intr_req) quiet = 1'b0; end
    chk("rerise_no_req", 32'(quiet), 32'd1);
    do_eret();
    tick();
    chk("rerise_req_next", 32'(intr_req), 32'd1);
    serve(10'h051, 2);

    // Reset during ENTER kills the pulse immediately.
    irq_in = 4'h0;
    tick();
    irq_in[3] = 1'b1;
    tick();
    ack_enter(10'h0AA, 3);
    rst_n = 1'b0;
    #1;
    chk("rst_enter_outputs", {intr_req, epc_w_en, jmp_en, epc_w_data, jmp_addr, pending, in_service}, 32'd0);
    irq_in = 4'h0;
    tick();
    rst_n = 1'b1;
    quiet = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (intr_req || jmp_en || epc_w_en) quiet = 1'b0;
      n += int'(pending != 4'h0);
    end
    chk("post_rst_quiet", 32'(quiet), 32'd1);
    chk("post_rst_pending", 32'(n), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt initiator paired with the CP0 register file.
- Detects rising edges on 4 external IRQ lines, holds them as pending and arbitrates by fixed priority.
- Requests a safe boundary from the pipeline. On grant it issues the hidden-instruction pulse: EPC write plus jump to the vector.
- Tracks the in-service source until eret returns control. Consumes the CP0 outputs intr_en and intr_mask; drives CP0 epc_w_en/epc_w_data.

Parameters:
- IM_ADDR_BIT, 10, instruction-memory word-address width.
- VEC_BASE, 10'h100, word address of the IRQ0 handler.
- VEC_STRIDE, 10'h020, word distance between consecutive handlers.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- irq_in  input  4  interrupt sources, synchronous to clk, rising-edge sensitive
- intr_en  input  1  global enable from CP0 status bit 0
- intr_mask  input  4  per-source enable from CP0 status[11:8]
- resume_pc  input  IM_ADDR_BIT  word address of the next instruction to resume at
- pipe_ack  input  1  pipeline at safe boundary, accepting the interrupt this cycle
- is_eret  input  1  eret retiring
- intr_req  output  1  interrupt request to the pipeline
- epc_w_en  output  1  one-cycle EPC write strobe to CP0
- epc_w_data  output  IM_ADDR_BIT  EPC value (latched resume_pc)
- jmp_en  output  1  one-cycle redirect strobe to the PC unit
- jmp_addr  output  IM_ADDR_BIT  handler address
- pending  output  4  pending bits
- in_service  output  4  one-hot active source, or 0

Behaviour:
- Reset: state IDLE; irq_prev, pending, in_service, latched id, latched pc all 0. Every output is 0.
- Reset mid-operation aborts everything, including ENTER and SERVICE, with no further pulses.
- Edge detect:
  - irq_prev <= irq_in each cycle; edge = irq_in & ~irq_prev.
  - Pending bit sets at the clock edge after the input rises.
  - An input already high at reset release counts as an edge.
- eligible = pending & intr_mask, qualified by intr_en. Priority: bit 3 highest, bit 0 lowest.
- FSM states:
  - IDLE: goes to REQ when intr_en and |eligible.
  - REQ:
    - intr_req = 1 (combinational from state).
    - If eligible becomes 0 or intr_en drops, go to IDLE with no side effects.
    - If pipe_ack is high at the edge:
      - latch id = highest eligible and latch resume_pc;
      - clear pending[id] and set in_service[id];
      - go to ENTER.
  - ENTER (exactly 1 cycle):
    - epc_w_en = 1, epc_w_data = latched pc;
    - jmp_en = 1, jmp_addr = VEC_BASE + id*VEC_STRIDE, truncated to IM_ADDR_BIT;
    - go to SERVICE.
  - SERVICE: on is_eret, clear in_service and go to IDLE. The next request can assert the following cycle.
- is_eret outside SERVICE is ignored.
- pipe_ack outside REQ is ignored.
- A new edge on the source being cleared in the same cycle leaves pending set; set wins.
- Edges keep accumulating in pending in all states. Multiple edges of one source before service collapse into one.
- Masked sources stay pending indefinitely and become eligible when unmasked.
- epc_w_data and jmp_addr hold their last values outside ENTER; consumers qualify them by the strobes.
- Latency: irq rise to intr_req is 2 cycles when IDLE with intr_en = 1. pipe_ack to epc_w_en/jmp_en is 1 cycle.

Test Plan:
- Reset, intr_en=1, mask=4'hF, irq_in[1] rises at cycle 5:
  - pending=4'b0010 at cycle 6; intr_req at cycle 7;
  - pipe_ack at cycle 9 with resume_pc=10'h045;
  - at cycle 10: epc_w_en=1, epc_w_data=10'h045, jmp_en=1, jmp_addr=10'h120, in_service=4'b0010;
  - is_eret at cycle 15 gives in_service=0 and state IDLE.
- irq_in[0] and irq_in[3] rise together, acked: jmp_addr=10'h160 and in_service=4'b1000. pending=4'b0001 remains. After eret, a second entry occurs with jmp_addr=10'h100.
- mask=4'b1101, irq_in[1] rises: pending[1]=1 and intr_req stays 0 for 20 cycles. Setting mask=4'hF then yields intr_req 1 cycle later.
- In REQ with irq 2 pending, intr_en drops before ack: intr_req deasserts next cycle, no epc_w_en, pending[2] still 1.
- During SERVICE of irq 2, irq_in[2] re-rises: no new request until eret. After eret, a second entry for irq 2 follows.
- Assert rst_n=0 during ENTER: all outputs are 0 immediately. After release with irq_in=0, no request.
